dcache_wt: RTL

- Direct-mapped, write-through, write-allocate data cache between the pipeline MEM stage and the 20-cycle block data memory.
- Serves lw hits with zero stall.
- Converts lw misses into block refills and every sw into a memory write-through.
- Asserts Stall to freeze the pipeline while a memory transaction is outstanding.

---
 rtl/dcache_wt.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/dcache_wt.sv
// Direct-mapped write-through, write-allocate data cache for the MEM stage.
// Hits on lw are served combinationally; misses and every sw go to memory.
module dcache_wt #(
    parameter int SETS       = 8,
    parameter int BLOCK_SIZE = 4
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic [31:0]             Address,
    input  logic [31:0]             Write_data,
    input  logic                    MemRead,
    input  logic                    MemWrite,
    output logic [31:0]             Read_data,
    output logic                    Stall,
    output logic [31:0]             Mem_Address,
    output logic [31:0]             Mem_Write_data,
    output logic                    ReadMiss,
    output logic                    MemWriteThrough,
    input  logic [32*BLOCK_SIZE-1:0] Mem_Read_data,
    input  logic                    ReadReady,
    input  logic                    WriteReady
);
    localparam int IB = $clog2(SETS);
    localparam int TB = 32 - IB - 4;

    typedef enum logic [2:0] {
        IDLE, REQ_RD, REQ_WR, REQ_RW, WAIT_RD, WAIT_WR, DONE
    } state_t;

    state_t state_q, state_d;

    logic [SETS-1:0] valid_q, valid_d;
    logic [TB-1:0]   tag_q  [SETS];
    logic [TB-1:0]   tag_d  [SETS];
    logic [31:0]     data_q [SETS][BLOCK_SIZE];
    logic [31:0]     data_d [SETS][BLOCK_SIZE];

    logic [TB-1:0] ltag_q, ltag_d;
    logic [IB-1:0] lidx_q, lidx_d;
    logic [1:0]    loff_q, loff_d;
    logic [31:0]   lwdata_q, lwdata_d;
    logic          lsw_q, lsw_d;
    logic          rm_q, rm_d;
    logic          wt_q, wt_d;

    logic [TB-1:0] tag_in;
    logic [IB-1:0] idx_in;
    logic [1:0]    off_in;
    logic          hit;
    logic          unused_addr;

    assign tag_in      = Address[31:IB+4];
    assign idx_in      = Address[IB+3:4];
    assign off_in      = Address[3:2];
    assign unused_addr = ^Address[1:0];
    assign hit         = valid_q[idx_in] && (tag_q[idx_in] == tag_in);

    assign Mem_Address     = {ltag_q, lidx_q, loff_q, 2'b00};
    assign Mem_Write_data  = lwdata_q;
    assign ReadMiss        = rm_q;
    assign MemWriteThrough = wt_q;

    always_comb begin
        state_d   = state_q;
        valid_d   = valid_q;
        tag_d     = tag_q;
        data_d    = data_q;
        ltag_d    = ltag_q;
        lidx_d    = lidx_q;
        loff_d    = loff_q;
        lwdata_d  = lwdata_q;
        lsw_d     = lsw_q;
        Stall     = 1'b0;
        Read_data = 32'h0;
        unique case (state_q)
            IDLE: begin
                if (MemWrite || (MemRead && !hit)) begin
                    Stall    = 1'b1;
                    ltag_d   = tag_in;
                    lidx_d   = idx_in;
                    loff_d   = off_in;
                    lwdata_d = Write_data;
                    lsw_d    = MemWrite;
                end
                if (MemWrite) begin
                    if (hit) begin
                        data_d[idx_in][off_in] = Write_data;
                        state_d = REQ_WR;
                    end else begin
                        state_d = REQ_RW;
                    end
                end else if (MemRead) begin
                    if (hit) Read_data = data_q[idx_in][off_in];
                    else     state_d   = REQ_RD;
                end
            end
            REQ_RD: begin
                Stall   = 1'b1;
                state_d = WAIT_RD;
            end
            REQ_WR: begin
                Stall   = 1'b1;
                state_d = WAIT_WR;
            end
            REQ_RW: begin
                Stall   = 1'b1;
                state_d = WAIT_RD;
            end
            WAIT_RD: begin
                Stall = 1'b1;
                if (ReadReady) begin
                    for (int i = 0; i < BLOCK_SIZE; i++)
                        data_d[lidx_q][i] = Mem_Read_data[32*i +: 32];
                    // store data wins over the stale word in the refill
                    if (lsw_q) data_d[lidx_q][loff_q] = lwdata_q;
                    tag_d[lidx_q]   = ltag_q;
                    valid_d[lidx_q] = 1'b1;
                    state_d         = DONE;
                end
            end
            WAIT_WR: begin
                Stall = 1'b1;
                if (WriteReady) state_d = DONE;
            end
            DONE: begin
                if (!lsw_q) Read_data = data_q[lidx_q][loff_q];
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        rm_d = (state_d == REQ_RD) || (state_d == REQ_RW);
        wt_d = (state_d == REQ_WR) || (state_d == REQ_RW);
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q  <= IDLE;
            valid_q  <= '0;
            ltag_q   <= '0;
            lidx_q   <= '0;
            loff_q   <= '0;
            lwdata_q <= '0;
            lsw_q    <= 1'b0;
            rm_q     <= 1'b0;
            wt_q     <= 1'b0;
            for (int s = 0; s < SETS; s++) begin
                tag_q[s] <= '0;
                for (int w = 0; w < BLOCK_SIZE; w++)
                    data_q[s][w] <= '0;
            end
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            data_q   <= data_d;
            ltag_q   <= ltag_d;
            lidx_q   <= lidx_d;
            loff_q   <= loff_d;
            lwdata_q <= lwdata_d;
            lsw_q    <= lsw_d;
            rm_q     <= rm_d;
            wt_q     <= wt_d;
        end
    end
endmodule
